// File: rtl/tap_shift_window.sv
// tap_shift_window: multi-channel shift window, programmable length, valid/ready, parallel taps.
// Optional build macro TAP_SHIFT_WINDOW_TAP_MASK_EN adds tap_valid and zero-masks empty taps.
module tap_shift_window #(
   parameter int DATA_BITS = 8,
   parameter int CHANNELS  = 1,
   parameter int LENGTH    = 16,
   parameter int LEN_BITS  = $clog2(LENGTH+1)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 flush,
   input  logic [LEN_BITS-1:0]                  length_sel,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [CHANNELS*DATA_BITS-1:0]        in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [CHANNELS*DATA_BITS-1:0]        out_data,
   output logic [LENGTH*CHANNELS*DATA_BITS-1:0] taps,
`ifdef TAP_SHIFT_WINDOW_TAP_MASK_EN
   output logic [LENGTH-1:0]                    tap_valid,
`endif
   output logic [LEN_BITS-1:0]                  fill_count
);

   localparam int W = CHANNELS*DATA_BITS;

   logic [W-1:0]        r_stage [LENGTH];
   logic [LEN_BITS-1:0] r_count;
   logic [LEN_BITS-1:0] r_len;
   logic [LEN_BITS-1:0] w_len_clamp;
   logic [W-1:0]        w_out;
   logic                w_push;
   logic                w_pop;

   always_comb begin
      if (length_sel == '0)
         w_len_clamp = LEN_BITS'(1);
      else if (length_sel > LEN_BITS'(LENGTH))
         w_len_clamp = LEN_BITS'(LENGTH);
      else
         w_len_clamp = length_sel;
   end

   assign out_valid  = (r_count == r_len);
   assign in_ready   = flush || (r_count < r_len) || out_ready;
   assign w_push     = in_valid && in_ready;
   // A pop landing on a flush is dropped; the flush owns the count.
   assign w_pop      = out_valid && out_ready && !flush;
   assign fill_count = r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LENGTH; i++)
            r_stage[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < LENGTH; i++)
            r_stage[i] <= '0;
         if (in_valid)
            r_stage[0] <= in_data;
      end else if (w_push) begin
         r_stage[0] <= in_data;
         for (int i = 1; i < LENGTH; i++)
            r_stage[i] <= r_stage[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_len   <= LEN_BITS'(LENGTH);
      end else if (flush) begin
         r_count <= in_valid ? LEN_BITS'(1) : '0;
         r_len   <= w_len_clamp;
      end else begin
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LEN_BITS'(1);
            2'b01:   r_count <= r_count - LEN_BITS'(1);
            default: r_count <= r_count;
         endcase
         // Length only changes while the window is empty and idle.
         if (r_count == '0 && !w_push)
            r_len <= w_len_clamp;
      end
   end

   always_comb begin
      w_out = r_stage[0];
      for (int i = 0; i < LENGTH; i++)
         if (LEN_BITS'(i) == r_len - LEN_BITS'(1))
            w_out = r_stage[i];
   end

   assign out_data = w_out;

   for (genvar g = 0; g < LENGTH; g++) begin : g_tap
`ifdef TAP_SHIFT_WINDOW_TAP_MASK_EN
      assign tap_valid[g]    = (LEN_BITS'(g) < r_count);
      assign taps[g*W +: W]  = tap_valid[g] ? r_stage[g] : '0;
`else
      assign taps[g*W +: W]  = r_stage[g];
`endif
   end

endmodule

// File: tb/tb_tap_shift_window.sv
// Directed bench for tap_shift_window: fill, backpressure, flush, length, async reset, taps.
module tb_tap_shift_window;

   localparam int DB  = 8;
   localparam int CH  = 2;
   localparam int LEN = 16;
   localparam int LB  = $clog2(LEN+1);
   localparam int W   = DB*CH;

   logic              clk;
   logic              reset;
   logic              flush;
   logic [LB-1:0]     length_sel;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_data;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic [LEN*W-1:0]  taps;
   logic [LB-1:0]     fill_count;
`ifdef TAP_SHIFT_WINDOW_TAP_MASK_EN
   logic [LEN-1:0]    tap_valid;
`endif

   int n_chk;
   int n_pass;

   tap_shift_window #(
      .DATA_BITS(DB), .CHANNELS(CH), .LENGTH(LEN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .length_sel (length_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .taps       (taps),
`ifdef TAP_SHIFT_WINDOW_TAP_MASK_EN
      .tap_valid  (tap_valid),
`endif
      .fill_count (fill_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (fill_count !== 5'd0) $display("FAIL rst_fill got %0d exp 0", fill_count); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_ovalid got %b exp 0", out_valid); else n_pass++;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_iready got %b exp 1", in_ready); else n_pass++;
      n_chk++; if (taps !== '0) $display("FAIL rst_taps got %h exp 0", taps); else n_pass++;
      n_chk++; if (out_data !== 16'h0) $display("FAIL rst_odata got %h exp 0", out_data); else n_pass++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_fill_stream();
      logic [7:0] b;
      logic [7:0] e;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         b = 8'(k);
         in_data = {b, b};
         step();
         n_chk++;
         if (fill_count !== 5'(k < 4 ? k : 4))
            $display("FAIL fill_cnt k=%0d got %0d", k, fill_count);
         else n_pass++;
         n_chk++;
         if (out_valid !== (k >= 4))
            $display("FAIL fill_ovalid k=%0d got %b exp %b", k, out_valid, k >= 4);
         else n_pass++;
         if (k >= 4) begin
            e = 8'(k - 3);
            n_chk++;
            if (out_data !== {e, e})
               $display("FAIL fill_odata k=%0d got %h exp %h", k, out_data, {e, e});
            else n_pass++;
         end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0909;
      #1;
      n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_iready got %b exp 0", in_ready); else n_pass++;
      for (int c = 0; c < 3; c++) begin
         step();
         n_chk++; if (fill_count !== 5'd4) $display("FAIL bp_fill c=%0d got %0d exp 4", c, fill_count); else n_pass++;
         n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_iready c=%0d got %b exp 0", c, in_ready); else n_pass++;
         n_chk++; if (taps[15:0] !== 16'h0808) $display("FAIL bp_tap0 c=%0d got %h exp 0808", c, taps[15:0]); else n_pass++;
         n_chk++; if (taps[63:48] !== 16'h0505) $display("FAIL bp_tap3 c=%0d got %h exp 0505", c, taps[63:48]); else n_pass++;
      end
      n_chk++; if (out_data !== 16'h0505) $display("FAIL bp_odata got %h exp 0505", out_data); else n_pass++;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_chk++; if (fill_count !== 5'd3) $display("FAIL pop_fill got %0d exp 3", fill_count); else n_pass++;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL pop_iready got %b exp 1", in_ready); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL pop_ovalid got %b exp 0", out_valid); else n_pass++;
   endtask

   task automatic test_flush();
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h00AA;
      #1;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL fl_iready got %b exp 1", in_ready); else n_pass++;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      n_chk++; if (fill_count !== 5'd1) $display("FAIL fl_fill got %0d exp 1", fill_count); else n_pass++;
      n_chk++; if (taps[15:0] !== 16'h00AA) $display("FAIL fl_tap0 got %h exp 00aa", taps[15:0]); else n_pass++;
      n_chk++; if (taps[LEN*W-1:16] !== '0) $display("FAIL fl_taprest got %h exp 0", taps[LEN*W-1:16]); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL fl_ovalid got %b exp 0", out_valid); else n_pass++;
   endtask

   task automatic test_length_change();
      in_valid = 1'b1;
      in_data  = 16'h1111;
      step();
      length_sel = 5'd7;
      in_data = 16'h2222;
      step();
      in_data = 16'h3333;
      step();
      in_valid = 1'b0;
      n_chk++; if (out_valid !== 1'b1) $display("FAIL len_hold_ovalid got %b exp 1", out_valid); else n_pass++;
      n_chk++; if (fill_count !== 5'd4) $display("FAIL len_hold_fill got %0d exp 4", fill_count); else n_pass++;
      n_chk++; if (out_data !== 16'h00AA) $display("FAIL len_hold_odata got %h exp 00aa", out_data); else n_pass++;
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_chk++; if (fill_count !== 5'd0) $display("FAIL drain_fill got %0d exp 0", fill_count); else n_pass++;
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_data = 16'h0100 + 16'(i);
         step();
         if (i == 5) begin
            n_chk++; if (out_valid !== 1'b0) $display("FAIL l7_early got %b exp 0", out_valid); else n_pass++;
         end
      end
      n_chk++; if (out_valid !== 1'b1) $display("FAIL l7_ovalid got %b exp 1", out_valid); else n_pass++;
      n_chk++; if (out_data !== 16'h0100) $display("FAIL l7_odata got %h exp 0100", out_data); else n_pass++;
      in_valid   = 1'b0;
      length_sel = 5'd0;
      flush      = 1'b1;
      step();
      flush     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h5A5A;
      step();
      n_chk++; if (out_valid !== 1'b1) $display("FAIL l1_ovalid got %b exp 1", out_valid); else n_pass++;
      n_chk++; if (out_data !== 16'h5A5A) $display("FAIL l1_odata got %h exp 5a5a", out_data); else n_pass++;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL l1_iready got %b exp 1", in_ready); else n_pass++;
      in_data = 16'h6B6B;
      step();
      n_chk++; if (out_data !== 16'h6B6B) $display("FAIL l1_thru got %h exp 6b6b", out_data); else n_pass++;
      n_chk++; if (fill_count !== 5'd1) $display("FAIL l1_fill got %0d exp 1", fill_count); else n_pass++;
      out_ready  = 1'b0;
      in_valid   = 1'b0;
      length_sel = 5'd20;
      flush      = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = 16'h0200 + 16'(i);
         step();
         if (i == 14) begin
            n_chk++; if (out_valid !== 1'b0) $display("FAIL l16_early got %b exp 0", out_valid); else n_pass++;
         end
      end
      in_valid = 1'b0;
      n_chk++; if (out_valid !== 1'b1) $display("FAIL l16_ovalid got %b exp 1", out_valid); else n_pass++;
      n_chk++; if (fill_count !== 5'd16) $display("FAIL l16_fill got %0d exp 16", fill_count); else n_pass++;
      n_chk++; if (out_data !== 16'h0200) $display("FAIL l16_odata got %h exp 0200", out_data); else n_pass++;
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      n_chk++; if (fill_count !== 5'd0) $display("FAIL ar_fill got %0d exp 0", fill_count); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL ar_ovalid got %b exp 0", out_valid); else n_pass++;
      n_chk++; if (taps !== '0) $display("FAIL ar_taps got %h exp 0", taps); else n_pass++;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_tap_mask();
      logic [15:0] e2;
      logic [15:0] e3;
      length_sel = 5'd0;
      step();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0A0A;
      step();
      in_data = 16'h0B0B;
      step();
      in_valid = 1'b0;
      step();
      out_ready  = 1'b0;
      n_chk++; if (fill_count !== 5'd0) $display("FAIL tm_empty got %0d exp 0", fill_count); else n_pass++;
      length_sel = 5'd4;
      step();
      in_valid = 1'b1;
      in_data  = 16'h0C0C;
      step();
      in_data = 16'h0D0D;
      step();
      in_valid = 1'b0;
`ifdef TAP_SHIFT_WINDOW_TAP_MASK_EN
      e2 = 16'h0000;
      e3 = 16'h0000;
      n_chk++; if (tap_valid !== 16'h0003) $display("FAIL tm_tvalid got %h exp 0003", tap_valid); else n_pass++;
`else
      e2 = 16'h0B0B;
      e3 = 16'h0A0A;
`endif
      n_chk++; if (fill_count !== 5'd2) $display("FAIL tm_fill got %0d exp 2", fill_count); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL tm_ovalid got %b exp 0", out_valid); else n_pass++;
      n_chk++; if (taps[15:0] !== 16'h0D0D) $display("FAIL tm_tap0 got %h exp 0d0d", taps[15:0]); else n_pass++;
      n_chk++; if (taps[31:16] !== 16'h0C0C) $display("FAIL tm_tap1 got %h exp 0c0c", taps[31:16]); else n_pass++;
      n_chk++; if (taps[47:32] !== e2) $display("FAIL tm_tap2 got %h exp %h", taps[47:32], e2); else n_pass++;
      n_chk++; if (taps[63:48] !== e3) $display("FAIL tm_tap3 got %h exp %h", taps[63:48], e3); else n_pass++;
      n_chk++; if (out_data !== 16'h0A0A) $display("FAIL tm_odata got %h exp 0a0a", out_data); else n_pass++;
   endtask

   initial begin
      n_chk      = 0;
      n_pass     = 0;
      reset      = 1'b1;
      flush      = 1'b0;
      length_sel = 5'd4;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      test_reset();
      test_fill_stream();
      test_backpressure();
      test_flush();
      test_length_change();
      test_async_reset();
      test_tap_mask();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tap_shift_window.md
Name: tap_shift_window

Overview:
- Parametrised multi-channel shift window with a run-time programmable active length.
- Adds a valid/ready handshake and backpressure, exposes every stage as a parallel tap, and provides a synchronous flush.
- Sits between pixel/sample streaming sources and windowed consumers (filters, correlators) that need both the delayed stream and the full window contents.

Parameters:
DATA_BITS, 8, bits per channel element
CHANNELS, 1, parallel lanes shifted in lock-step
LENGTH, 16, maximum number of stages (>=2)
LEN_BITS, $clog2(LENGTH+1), width of length_sel and fill_count

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of the window
length_sel  input  LEN_BITS  requested active length L
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle
in_data  input  CHANNELS*DATA_BITS  new element; channel c at bits [c*DATA_BITS +: DATA_BITS]
out_valid  output  1  window complete; out_data valid
out_ready  input  1  consumer takes out_data
out_data  output  CHANNELS*DATA_BITS  oldest element, stage[L-1]
taps  output  LENGTH*CHANNELS*DATA_BITS  stage i at slice i; stage 0 is newest
fill_count  output  LEN_BITS  elements resident, 0..L

Behaviour:
- Reset (async assert) sets:
  - all stages to 0, fill_count=0;
  - active length L to LENGTH;
  - in_ready=1, out_valid=0, out_data=0, taps=0.
  - Deassertion is synchronous to clk, handled by the integration reset synchroniser.
- Handshakes:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
- Combinational outputs:
  - out_valid = (fill_count == L).
  - in_ready = (fill_count < L) || out_ready. Backpressure only applies when the window is full and the consumer stalls.
  - out_data = stage[L-1]; the value is don't-care when out_valid=0 (implemented as the raw stage).
- Push: stage[i] <= stage[i-1] for i=1..LENGTH-1, and stage[0] <= in_data. Stages at and beyond L also shift; they are not observed on out_data.
- fill_count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged (pure shift)
  - neither: hold, and stages hold.
- Pop only: stages unchanged and only fill_count decrements. The oldest element is then stage[fill_count-1], so out_data is taken at index L-1 only while count==L.
- Zero-latency pass relation: an element pushed at cycle t appears on out_data once L-1 further pushes have occurred.
- length_sel sampling:
  - Sampled into L only on cycles where fill_count==0 and there is no push.
  - Clamping: 0 -> 1; values > LENGTH -> LENGTH.
  - Changes at other times are ignored until the window next empties.
- flush priority is over normal operation:
  - Clears fill_count and all stages to 0.
  - If in_valid is also high, in_data is loaded into stage[0] and fill_count=1. in_ready reads 1 during flush.
  - A pop coinciding with flush is discarded; out_valid is still driven from pre-flush state, and the consumer must not rely on it.
  - L is re-sampled from length_sel in a flush cycle.
- Boundaries:
  - L=1 degenerates to a 1-entry register slice with full throughput.
  - Full with out_ready=0: in_ready=0, and the window and taps hold.
  - Count never exceeds L and never underflows, since pop requires out_valid.
- reset asserted mid-stream discards all contents immediately (asynchronous); it does not wait for a clock edge.

Optional Feature:
- Macro: TAP_SHIFT_WINDOW_TAP_MASK_EN.
- Defined:
  - Adds output tap_valid [LENGTH], with bit i = (i < fill_count).
  - taps slices with tap_valid[i]=0 read zero, which is a combinational mask on the taps port only.
- Undefined: no tap_valid port; taps present raw stage contents, including stale data.
- out_data is identical in both builds.

Test Plan:
- Fill/stream with L=4, CHANNELS=2, DATA_BITS=8, out_ready=1:
  - Stimulus: push 0x0101, 0x0202, … 0x0808.
  - Required: out_valid rises after the 4th push with out_data=0x0101; sustained pushes yield 0x0202, 0x0303 one per cycle; fill_count stays 4.
- Backpressure with L=4 full and out_ready=0, in_valid=1 for 3 cycles:
  - Required: in_ready=0, taps unchanged, fill_count=4.
  - Then out_ready=1 alone: pop, fill_count=3, in_ready=1.
- Flush with load, 3 resident elements:
  - Stimulus: flush=1 and in_valid=1 with in_data=0xAA.
  - Required next cycle: fill_count=1, taps[0]=0xAA, taps[1..]=0, out_valid=0.
- Length change timing:
  - Stimulus: set length_sel=7 while fill_count=2.
  - Required: L stays 4, so out_valid occurs after 4 elements. After draining to 0, 7 is adopted; length_sel=0 gives L=1; length_sel=20 with LENGTH=16 gives L=16.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges while full.
  - Required: fill_count=0, out_valid=0, taps=0 immediately, with no clock edge required.
- Mask build (TAP_SHIFT_WINDOW_TAP_MASK_EN) after 2 pushes with L=4:
  - Required: tap_valid=4'b0011, taps[2..3]=0.
  - Without the macro: taps[2..3] show prior contents.
